// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if
//   Bundles the decoded-field inputs and the latch-control outputs of the
//   pipeline hazard controller.
//   master : pipeline/decoder side (drives decoded fields, sees controls)
//   slave  : hazard controller (sees decoded fields, drives controls)
//   Signals:
//     fd_src1/fd_src2/fd_src_vld     F/D source registers and read flags
//     dx_opcode/dx_aluop/dx_rd       D/X opcode, aluop, destination
//     br_taken_x                     X-stage taken branch/jump/jr/bex
//     md_ready                       mult/div result valid
//     pc_en/fd_en/dx_en/xm_en/mw_en  latch enables
//     fd_flush/dx_flush/xm_flush     latch loads NOP at next edge
//     md_start/md_busy/md_err        mult/div sequencing status
//     stall_cnt                      saturating count of pc_en=0 cycles
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       fd_src1;
  logic [4:0]       fd_src2;
  logic [1:0]       fd_src_vld;
  logic [4:0]       dx_opcode;
  logic [4:0]       dx_aluop;
  logic [4:0]       dx_rd;
  logic             br_taken_x;
  logic             md_ready;
  logic             pc_en;
  logic             fd_en;
  logic             dx_en;
  logic             xm_en;
  logic             mw_en;
  logic             fd_flush;
  logic             dx_flush;
  logic             xm_flush;
  logic             md_start;
  logic             md_busy;
  logic             md_err;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output fd_src1, fd_src2, fd_src_vld, dx_opcode, dx_aluop, dx_rd,
           br_taken_x, md_ready,
    input  pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush, xm_flush,
           md_start, md_busy, md_err, stall_cnt
  );

  modport slave (
    input  fd_src1, fd_src2, fd_src_vld, dx_opcode, dx_aluop, dx_rd,
           br_taken_x, md_ready,
    output pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush, xm_flush,
           md_start, md_busy, md_err, stall_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central stall/flush controller for the 5-stage pipeline. Detects
//   load-use hazards, squashes wrong-path instructions on taken X-stage
//   branches, and sequences the multi-cycle mult/div unit (IDLE/BUSY).
//   Ports:
//     clk   pipeline clock, rising edge
//     clrn  asynchronous active-low reset
//     bus   pipeline_hazard_ctrl_if.slave (decoded fields in, controls out)
//   Parameters:
//     CNT_W       width of the saturating stall-cycle counter
//     MD_TIMEOUT  BUSY cycles before forced release (timeout build only)
//   Build option:
//     HAZARD_MD_TIMEOUT_EN  when defined, a BUSY-cycle timer forces release
//                           after MD_TIMEOUT cycles and sets sticky md_err;
//                           otherwise BUSY waits for md_ready indefinitely.
module pipeline_hazard_ctrl #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned MD_TIMEOUT = 40
) (
  input logic                   clk,
  input logic                   clrn,
  pipeline_hazard_ctrl_if.slave bus
);

  typedef enum logic {IDLE, BUSY} md_state_t;

  md_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic             dx_load;
  logic             dx_md;
  logic             lu_haz;
  logic             tmo;
  logic             err;
  logic             release_md;

  logic pc_en_c, fd_en_c, dx_en_c;
  logic fd_flush_c, dx_flush_c, xm_flush_c, md_start_c;

  if (MD_TIMEOUT < 1) begin : g_bad_timeout
    $error("MD_TIMEOUT must be at least 1");
  end

  assign dx_load = (bus.dx_opcode == 5'b01000);
  assign dx_md   = (bus.dx_opcode == 5'b00000) &&
                   (bus.dx_aluop == 5'b00110 || bus.dx_aluop == 5'b00111);
  assign lu_haz  = dx_load && (bus.dx_rd != 5'd0) &&
                   ((bus.fd_src_vld[0] && bus.fd_src1 == bus.dx_rd) ||
                    (bus.fd_src_vld[1] && bus.fd_src2 == bus.dx_rd));

`ifdef HAZARD_MD_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(MD_TIMEOUT + 1);
  logic [TMR_W-1:0] tmr;

  // tmr holds the number of BUSY cycles already completed, so the cycle on
  // which it equals MD_TIMEOUT-1 is the MD_TIMEOUT-th BUSY cycle.
  assign tmo = (state == BUSY) && !bus.md_ready &&
               (tmr == TMR_W'(MD_TIMEOUT - 1));

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      tmr <= '0;
      err <= 1'b0;
    end else begin
      if (state == IDLE || release_md) tmr <= '0;
      else                             tmr <= tmr + 1'b1;
      if (tmo) err <= 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  assign release_md = bus.md_ready || tmo;

  always_comb begin
    pc_en_c    = 1'b1;
    fd_en_c    = 1'b1;
    dx_en_c    = 1'b1;
    fd_flush_c = 1'b0;
    dx_flush_c = 1'b0;
    xm_flush_c = 1'b0;
    md_start_c = 1'b0;
    case (state)
      IDLE: begin
        if (bus.br_taken_x) begin
          // Wrong-path squash also kills a mult/div sitting in D/X.
          fd_flush_c = 1'b1;
          dx_flush_c = 1'b1;
        end else if (dx_md) begin
          md_start_c = 1'b1;
          pc_en_c    = 1'b0;
          fd_en_c    = 1'b0;
          dx_en_c    = 1'b0;
          xm_flush_c = 1'b1;
        end else if (lu_haz) begin
          pc_en_c    = 1'b0;
          fd_en_c    = 1'b0;
          dx_flush_c = 1'b1;
        end
      end
      BUSY: begin
        // Release cycle leaves everything enabled so X/M captures the result.
        if (!release_md) begin
          pc_en_c    = 1'b0;
          fd_en_c    = 1'b0;
          dx_en_c    = 1'b0;
          xm_flush_c = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (dx_md && !bus.br_taken_x) state <= BUSY;
        BUSY: if (release_md)               state <= IDLE;
      endcase
      if (!pc_en_c && cnt != '1) cnt <= cnt + 1'b1;
    end
  end

  assign bus.pc_en     = pc_en_c;
  assign bus.fd_en     = fd_en_c;
  assign bus.dx_en     = dx_en_c;
  assign bus.xm_en     = 1'b1;
  assign bus.mw_en     = 1'b1;
  assign bus.fd_flush  = fd_flush_c;
  assign bus.dx_flush  = dx_flush_c;
  assign bus.xm_flush  = xm_flush_c;
  assign bus.md_start  = md_start_c;
  assign bus.md_busy   = (state == BUSY);
  assign bus.md_err    = err;
  assign bus.stall_cnt = cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;
  localparam int unsigned MD_TIMEOUT = 40;
`ifdef HAZARD_MD_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  localparam logic [4:0] OP_LW  = 5'b01000;
  localparam logic [4:0] OP_R   = 5'b00000;
  localparam logic [4:0] OP_ADD = 5'b00001;
  localparam logic [4:0] AL_MUL = 5'b00110;
  localparam logic [4:0] AL_DIV = 5'b00111;

  logic clk = 1'b0;
  logic clrn = 1'b0;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(16)) hif();
  pipeline_hazard_ctrl_if #(.CNT_W(4))  sif();

  pipeline_hazard_ctrl #(.CNT_W(16), .MD_TIMEOUT(MD_TIMEOUT)) dut (
    .clk(clk), .clrn(clrn), .bus(hif)
  );
  pipeline_hazard_ctrl #(.CNT_W(4), .MD_TIMEOUT(MD_TIMEOUT)) dut_sat (
    .clk(clk), .clrn(clrn), .bus(sif)
  );

  assign sif.fd_src1    = hif.fd_src1;
  assign sif.fd_src2    = hif.fd_src2;
  assign sif.fd_src_vld = hif.fd_src_vld;
  assign sif.dx_opcode  = hif.dx_opcode;
  assign sif.dx_aluop   = hif.dx_aluop;
  assign sif.dx_rd      = hif.dx_rd;
  assign sif.br_taken_x = hif.br_taken_x;
  assign sif.md_ready   = hif.md_ready;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state: busy flag, BUSY cycles completed, sticky error,
  // unbounded stall count (saturation applied at comparison time).
  bit          m_busy = 1'b0;
  int          m_timer = 0;
  bit          m_err = 1'b0;
  int          m_cnt = 0;
  bit          nx_busy, nx_tmo;
  logic        exp_pc;
  logic [10:0] exp_o;

  function automatic logic [10:0] dut_o();
    return {hif.pc_en, hif.fd_en, hif.dx_en, hif.xm_en, hif.mw_en,
            hif.fd_flush, hif.dx_flush, hif.xm_flush,
            hif.md_start, hif.md_busy, hif.md_err};
  endfunction

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  // Applies inputs, then derives the expected outputs from the priority table.
  task automatic drive(input logic [4:0] s1, input logic [4:0] s2,
                       input logic [1:0] v, input logic [4:0] op,
                       input logic [4:0] alu, input logic [4:0] rd,
                       input logic br, input logic rdy);
    bit ld, md, lu, tmo;
    logic pc, fd, dx, fdf, dxf, xmf, st;
    hif.fd_src1 = s1; hif.fd_src2 = s2; hif.fd_src_vld = v;
    hif.dx_opcode = op; hif.dx_aluop = alu; hif.dx_rd = rd;
    hif.br_taken_x = br; hif.md_ready = rdy;
    #1;
    ld  = (op == OP_LW);
    md  = (op == OP_R) && (alu == AL_MUL || alu == AL_DIV);
    lu  = ld && rd != 0 && ((v[0] && s1 == rd) || (v[1] && s2 == rd));
    tmo = TMO_EN && m_busy && !rdy && (m_timer + 1 == int'(MD_TIMEOUT));
    {pc, fd, dx, fdf, dxf, xmf, st} = 7'b1110000;
    if (!m_busy && br) begin fdf = 1; dxf = 1; end
    else if (!m_busy && md) begin st = 1; pc = 0; fd = 0; dx = 0; xmf = 1; end
    else if (m_busy && !rdy && !tmo) begin pc = 0; fd = 0; dx = 0; xmf = 1; end
    else if (m_busy) begin pc = 1; end
    else if (lu) begin pc = 0; fd = 0; dxf = 1; end
    exp_o   = {pc, fd, dx, 1'b1, 1'b1, fdf, dxf, xmf, st, m_busy, m_err};
    exp_pc  = pc;
    nx_busy = m_busy ? !(rdy || tmo) : (md && !br);
    nx_tmo  = tmo;
  endtask

  task automatic tick();
    @(posedge clk);
    if (clrn) begin
      if (!exp_pc && m_cnt < 65535) m_cnt++;
      m_timer = (m_busy && nx_busy) ? m_timer + 1 : 0;
      if (nx_tmo) m_err = 1'b1;
      m_busy = nx_busy;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic model_reset();
    m_busy = 0; m_timer = 0; m_err = 0; m_cnt = 0;
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    model_reset();
    @(negedge clk);
    drive(1, 2, 2'b00, OP_ADD, 0, 3, 0, 0);
    checks++;
    if (dut_o() !== exp_o) begin errors++;
      $display("FAIL reset_outs cyc %0d got %b required %b", cyc, dut_o(), exp_o); end
    checks++;
    if (hif.stall_cnt !== 16'd0) begin errors++;
      $display("FAIL reset_cnt got %0d required 0", hif.stall_cnt); end
    tick();
    clrn = 1'b1;
  endtask

  task automatic test_load_use();
    logic [4:0] s1 [4] = '{5, 9, 0, 9};
    logic [4:0] s2 [4] = '{9, 9, 0, 5};
    logic [1:0] vl [4] = '{2'b01, 2'b01, 2'b00, 2'b10};
    logic [4:0] rd [4] = '{5, 0, 5, 5};
    for (int i = 0; i < 4; i++) begin
      drive(s1[i], s2[i], (i == 2) ? 2'b00 : vl[i], OP_LW, 0,
            (i == 2) ? 5'd5 : rd[i], 0, 0);
      if (i == 2) hif.fd_src1 = 5;
      drive(hif.fd_src1, s2[i], vl[i], OP_LW, 0, rd[i], 0, 0);
      checks++;
      if (dut_o() !== exp_o) begin errors++;
        $display("FAIL load_use[%0d] cyc %0d got %b required %b", i, cyc, dut_o(), exp_o); end
      tick();
      drive(1, 2, 2'b11, OP_ADD, 0, 3, 0, 0);
      checks++;
      if (dut_o() !== exp_o || hif.stall_cnt !== 16'(m_cnt)) begin errors++;
        $display("FAIL load_use_after[%0d] got %b cnt %0d required %b cnt %0d",
                 i, dut_o(), hif.stall_cnt, exp_o, m_cnt); end
      tick();
    end
  endtask

  task automatic test_mult();
    int starts = 0;
    int base = m_cnt;
    for (int i = 0; i <= 6; i++) begin
      drive(1, 2, 2'b11, OP_R, AL_MUL, 7, 0, (i == 6));
      starts += int'(hif.md_start);
      checks++;
      if (dut_o() !== exp_o) begin errors++;
        $display("FAIL mult[%0d] got %b required %b", i, dut_o(), exp_o); end
      tick();
    end
    drive(1, 2, 2'b11, OP_ADD, 0, 3, 0, 0);
    checks++;
    if (starts != 1 || hif.stall_cnt !== 16'(base + 6)) begin errors++;
      $display("FAIL mult_summary starts %0d cnt %0d required 1 and %0d",
               starts, hif.stall_cnt, base + 6); end
    tick();
  endtask

  task automatic test_branch_squash();
    drive(1, 2, 2'b11, OP_R, AL_DIV, 7, 1, 0);
    checks++;
    if (dut_o() !== exp_o) begin errors++;
      $display("FAIL br_squash got %b required %b", dut_o(), exp_o); end
    tick();
    drive(1, 2, 2'b11, OP_ADD, 0, 3, 0, 1);
    checks++;
    if (dut_o() !== exp_o || hif.md_busy !== 1'b0) begin errors++;
      $display("FAIL br_squash_after got %b required %b", dut_o(), exp_o); end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 9; i++) begin
      drive(1, 2, 2'b11, OP_R, (i % 2) ? AL_DIV : AL_MUL, 7, 0, (i % 3 == 2));
      checks++;
      if (dut_o() !== exp_o) begin errors++;
        $display("FAIL back_to_back[%0d] got %b required %b", i, dut_o(), exp_o); end
      tick();
    end
    drive(1, 2, 2'b11, OP_ADD, 0, 3, 0, 1);
    tick();
  endtask

  task automatic test_reset_busy();
    drive(1, 2, 2'b11, OP_R, AL_MUL, 7, 0, 0);
    tick();
    drive(1, 2, 2'b11, OP_R, AL_MUL, 7, 0, 0);
    tick();
    drive(1, 2, 2'b11, OP_R, AL_MUL, 7, 0, 0);
    #2 clrn = 1'b0;
    model_reset();
    #1;
    checks++;
    if (hif.md_busy !== 1'b0 || hif.stall_cnt !== 16'd0 || sif.stall_cnt !== 4'd0) begin errors++;
      $display("FAIL reset_busy busy %b cnt %0d required 0 0", hif.md_busy, hif.stall_cnt); end
    @(negedge clk);
    cyc++;
    clrn = 1'b1;
    drive(1, 2, 2'b11, OP_ADD, 0, 3, 0, 1);
    checks++;
    if (dut_o() !== exp_o) begin errors++;
      $display("FAIL reset_busy_ready got %b required %b", dut_o(), exp_o); end
    tick();
    drive(1, 2, 2'b11, OP_ADD, 0, 3, 0, 0);
    checks++;
    if (dut_o() !== exp_o || hif.stall_cnt !== 16'd0) begin errors++;
      $display("FAIL reset_busy_after got %b cnt %0d required %b 0", dut_o(), hif.stall_cnt, exp_o); end
    tick();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 22; i++) begin
      drive(1, 2, 2'b11, OP_R, AL_MUL, 7, 0, (i == 21));
      checks++;
      if (dut_o() !== exp_o || hif.stall_cnt !== 16'(m_cnt) ||
          sif.stall_cnt !== 4'(sat15(m_cnt))) begin errors++;
        $display("FAIL saturation[%0d] got %b cnt %0d sat %0d required %b %0d %0d",
                 i, dut_o(), hif.stall_cnt, sif.stall_cnt, exp_o, m_cnt, sat15(m_cnt)); end
      tick();
    end
  endtask

`ifdef HAZARD_MD_TIMEOUT_EN
  task automatic test_timeout();
    drive(1, 2, 2'b11, OP_R, AL_MUL, 7, 0, 0);
    tick();
    for (int i = 1; i <= 40; i++) begin
      drive(1, 2, 2'b11, OP_R, AL_MUL, 7, 0, 0);
      checks++;
      if (dut_o() !== exp_o) begin errors++;
        $display("FAIL timeout[%0d] got %b required %b", i, dut_o(), exp_o); end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1, 2, 2'b11, OP_ADD, 0, 3, 0, 0);
      checks++;
      if (dut_o() !== exp_o || hif.md_err !== 1'b1) begin errors++;
        $display("FAIL timeout_err[%0d] got %b required %b", i, dut_o(), exp_o); end
      tick();
    end
  endtask
`endif

  task automatic test_random();
    logic [4:0] op, alu;
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       op = OP_LW;
        1:       op = OP_R;
        2:       op = 5'($urandom);
        default: op = OP_ADD;
      endcase
      alu = ($urandom_range(0, 2) != 0) ? (($urandom_range(0, 1) != 0) ? AL_MUL : AL_DIV)
                                        : 5'($urandom);
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 2'($urandom),
            op, alu, 5'($urandom_range(0, 3)),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
      checks++;
      if (dut_o() !== exp_o || hif.stall_cnt !== 16'(m_cnt) ||
          sif.stall_cnt !== 4'(sat15(m_cnt))) begin errors++;
        $display("FAIL random[%0d] got %b cnt %0d sat %0d required %b %0d %0d",
                 i, dut_o(), hif.stall_cnt, sif.stall_cnt, exp_o, m_cnt, sat15(m_cnt)); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mult();
    test_branch_squash();
    test_back_to_back();
    test_reset_busy();
    test_saturation();
`ifdef HAZARD_MD_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
